// File: rtl/encoder_fault_test_ctrl.sv
// Built-in self-test sequencer for a WIDTH-input priority encoder: sweeps every
// input vector, compares the EUT response with a golden model and reports fault statistics.
module encoder_fault_test_ctrl #(
  parameter int WIDTH         = 4,
  parameter int OUT_W         = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] eut_d,
  input  logic [OUT_W-1:0] eut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   fail_count,
  output logic [WIDTH-1:0] first_fail_vec,
  output logic [OUT_W-1:0] first_fail_y,
  output logic [OUT_W-1:0] err_bits
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] APPLY   = 2'd1;
  localparam logic [1:0] COMPARE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] golden;
  logic [OUT_W-1:0] diff;
  logic             mismatch;
  logic             last_vec;
  logic [WIDTH:0]   fail_next;

  // Golden model: later iterations overwrite earlier ones, so the highest set bit wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    golden = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (eut_d[i]) golden = OUT_W'(i);
    end
  end

  assign diff      = golden ^ eut_y;
  assign mismatch  = |diff;
  assign last_vec  = &eut_d;
  assign fail_next = fail_count + {{WIDTH{1'b0}}, mismatch};
  assign busy      = (state == APPLY) || (state == COMPARE);

  // eut_d doubles as the vector counter; explicit all-ones detection ends the sweep before it wraps.
  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      eut_d          <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_vec <= '0;
      first_fail_y   <= '0;
      err_bits       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= APPLY;
            cnt            <= SETTLE_INIT;
            eut_d          <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_vec <= '0;
            first_fail_y   <= '0;
            err_bits       <= '0;
          end
        end
        APPLY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= COMPARE;
        end
        COMPARE: begin
          if (mismatch) begin
            fail_count <= fail_next;
            err_bits   <= err_bits | diff;
            if (fail_count == '0) begin
              first_fail_vec <= eut_d;
              first_fail_y   <= eut_y;
            end
          end
          if (last_vec) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= (fail_next == '0);
          end else begin
            state <= APPLY;
            eut_d <= eut_d + 1'b1;
            cnt   <= SETTLE_INIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_fault_test_ctrl.sv
// Self-checking bench: a behavioural EUT with injectable stuck-at faults, a result
// scoreboard filled at launch time and drained when the run reports done.
module tb_encoder_fault_test_ctrl;

  typedef struct {
    int         lat;
    logic       pass;
    logic [4:0] fc;
    logic [3:0] ffv;
    logic [1:0] ffy;
    logic [1:0] eb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  int         fault = 0;   // 0 none, 1 Y[1] stuck-at-0, 2 Y[0] stuck-at-1

  logic [3:0] eut_d, eut_d2;
  logic [1:0] eut_y, eut_y2;
  logic       busy, done, pass, busy2, done2, pass2;
  logic [4:0] fail_count, fail_count2;
  logic [3:0] first_fail_vec, first_fail_vec2;
  logic [1:0] first_fail_y, first_fail_y2, err_bits, err_bits2;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [1:0] prio(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic logic [1:0] faulty(input logic [1:0] y, input int f);
    case (f)
      1:       return y & 2'b01;
      2:       return y | 2'b01;
      default: return y;
    endcase
  endfunction

  function automatic exp_t model(input int f, input int settle);
    exp_t e;
    e.lat = 16 * (settle + 1);
    e.fc = '0; e.ffv = '0; e.ffy = '0; e.eb = '0;
    for (int v = 0; v < 16; v++) begin
      logic [1:0] g, y;
      g = prio(4'(v));
      y = faulty(g, f);
      if (y != g) begin
        if (e.fc == 0) begin
          e.ffv = 4'(v);
          e.ffy = y;
        end
        e.fc++;
        e.eb |= g ^ y;
      end
    end
    e.pass = (e.fc == 0);
    return e;
  endfunction

  always_comb eut_y  = faulty(prio(eut_d), fault);
  always_comb eut_y2 = prio(eut_d2);

  encoder_fault_test_ctrl #(.WIDTH(4), .OUT_W(2), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .eut_d(eut_d), .eut_y(eut_y),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .first_fail_vec(first_fail_vec), .first_fail_y(first_fail_y), .err_bits(err_bits)
  );

  encoder_fault_test_ctrl #(.WIDTH(4), .OUT_W(2), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start2), .eut_d(eut_d2), .eut_y(eut_y2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_count(fail_count2),
    .first_fail_vec(first_fail_vec2), .first_fail_y(first_fail_y2), .err_bits(err_bits2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".eut_d"}, 32'(eut_d), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".pass"}, 32'(pass), 0);
    check({tag, ".fail_count"}, 32'(fail_count), 0);
    check({tag, ".first_fail_vec"}, 32'(first_fail_vec), 0);
    check({tag, ".first_fail_y"}, 32'(first_fail_y), 0);
    check({tag, ".err_bits"}, 32'(err_bits), 0);
  endtask

  // Leaves the bench at the falling edge just after the edge that samples start.
  task automatic launch();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Cycles are counted from the start-sampling edge; optionally re-pulses start mid-run.
  task automatic wait_and_score(input string tag, input int repulse_at);
    exp_t e;
    int   n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      start = (n == repulse_at);
      if (n == repulse_at) check({tag, ".busy_at_repulse"}, 32'(busy), 1);
    end
    start = 1'b0;
    e = sb.pop_front();
    check({tag, ".latency"}, n, e.lat);
    check({tag, ".done"}, 32'(done), 1);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".pass"}, 32'(pass), 32'(e.pass));
    check({tag, ".fail_count"}, 32'(fail_count), 32'(e.fc));
    check({tag, ".first_fail_vec"}, 32'(first_fail_vec), 32'(e.ffv));
    check({tag, ".first_fail_y"}, 32'(first_fail_y), 32'(e.ffy));
    check({tag, ".err_bits"}, 32'(err_bits), 32'(e.eb));
  endtask

  initial begin
    exp_t e6;
    int   n, hold, bad, changes;
    logic [3:0] prev;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // Fault-free sweep.
    fault = 0;
    sb.push_back(model(0, 1));
    launch();
    check("t1.busy_after_start", 32'(busy), 1);
    wait_and_score("t1", -1);
    repeat (3) @(negedge clk);
    check("t1.done_held", 32'(done), 1);

    // Y[1] stuck-at-0.
    fault = 1;
    sb.push_back(model(1, 1));
    launch();
    wait_and_score("t2", -1);

    // Y[0] stuck-at-1.
    fault = 2;
    sb.push_back(model(2, 1));
    launch();
    wait_and_score("t3", -1);

    // Abort mid-run, then a clean rerun with the same fault.
    fault = 1;
    launch();
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_reset_state("t4.abort");
    sb.push_back(model(1, 1));
    launch();
    wait_and_score("t4.rerun", -1);

    // Start re-pulsed while busy is ignored.
    fault = 0;
    sb.push_back(model(0, 1));
    launch();
    wait_and_score("t5.repulse", 5);

    // Restart from DONE after a faulty run clears statistics immediately.
    fault = 1;
    sb.push_back(model(1, 1));
    launch();
    wait_and_score("t5.faulty", -1);
    fault = 0;
    sb.push_back(model(0, 1));
    launch();
    check("t5.restart.done", 32'(done), 0);
    check("t5.restart.busy", 32'(busy), 1);
    check("t5.restart.fail_count", 32'(fail_count), 0);
    check("t5.restart.err_bits", 32'(err_bits), 0);
    check("t5.restart.first_fail_vec", 32'(first_fail_vec), 0);
    wait_and_score("t5.restart", -1);

    // Longer settle time on the second instance.
    e6 = model(0, 3);
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    prev = eut_d2; hold = 1; bad = 0; changes = 0; n = 0;
    while (!done2 && n < 400) begin
      @(negedge clk);
      n++;
      if (eut_d2 == prev) hold++;
      else begin
        if (hold != 4) bad++;
        changes++;
        prev = eut_d2;
        hold = 1;
      end
    end
    check("t6.latency", n, e6.lat);
    check("t6.hold_violations", bad, 0);
    check("t6.vector_changes", changes, 15);
    check("t6.pass", 32'(pass2), 32'(e6.pass));
    check("t6.fail_count", 32'(fail_count2), 32'(e6.fc));
    check("t6.done", 32'(done2), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
